prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a program image over a byte stream and writes it into
// the 12-bit instruction memory. The CPU is held in reset while loading and
// after a failed load.
// Stream: HDR_HI, HDR_LO (11-bit word count), then W_HI/W_LO per word.
// Optional feature macro: LOADER_CHECKSUM_EN. When defined, an 8-bit checksum
// byte follows the payload. The load succeeds only if the payload bytes plus
// the checksum byte sum to zero (mod 256).
module prog_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [10:0] mem_addr,
  output logic [11:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_W_HI,
    S_W_LO,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  // Largest program that fits the address space of the loaded CPU.
  localparam logic [10:0] MAX_WORDS = 11'd1024;

  state_t      state_reg, state_next;
  logic [10:0] addr_reg, addr_next;
  logic [10:0] count_reg, count_next;
  logic [3:0]  whi_reg, whi_next;
  logic [10:0] mem_addr_reg, mem_addr_next;
  logic [11:0] mem_wdata_reg, mem_wdata_next;

  logic        xfer;
  logic [10:0] hdr_count;
  logic [10:0] addr_inc;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_reg, csum_next;
  logic [7:0]  csum_sum;
  assign csum_sum = csum_reg + in_data;
`endif

  // The loader takes a byte only in states that expect one.
  assign in_ready = (state_reg == S_HDR_HI) || (state_reg == S_HDR_LO) ||
                    (state_reg == S_W_HI)   || (state_reg == S_W_LO)   ||
                    (state_reg == S_CHK);
  assign xfer      = in_valid && in_ready;
  assign hdr_count = {count_reg[10:8], in_data};
  assign addr_inc  = addr_reg + 11'd1;

  // Status outputs depend only on the state. Write address and data are
  // registered, so they keep their values between writes.
  assign mem_we    = (state_reg == S_WRITE);
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = !((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                       (state_reg == S_ERR));
  assign cpu_hold  = !((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign done      = (state_reg == S_DONE);
  assign error     = (state_reg == S_ERR);

  // State and datapath registers. Reset aborts any session in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      count_reg     <= '0;
      whi_reg       <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_reg      <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      count_reg     <= count_next;
      whi_reg       <= whi_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
`ifdef LOADER_CHECKSUM_EN
      csum_reg      <= csum_next;
`endif
    end
  end

  // Next-state logic. Every stream state waits for a transfer before it
  // advances.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    count_next     = count_reg;
    whi_next       = whi_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
`ifdef LOADER_CHECKSUM_EN
    csum_next      = csum_reg;
`endif

    case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_next = S_HDR_HI;
          addr_next  = '0;
          count_next = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_next  = '0;
`endif
        end
      end

      S_HDR_HI: begin
        if (xfer) begin
          if (in_data[7:3] != 5'd0) begin
            state_next = S_ERR;
          end else begin
            count_next = {in_data[2:0], 8'h00};
            state_next = S_HDR_LO;
          end
        end
      end

      S_HDR_LO: begin
        if (xfer) begin
          count_next = hdr_count;
          if (hdr_count == 11'd0) begin
            state_next = S_DONE;
          end else if (hdr_count > MAX_WORDS) begin
            state_next = S_ERR;
          end else begin
            state_next = S_W_HI;
          end
        end
      end

      S_W_HI: begin
        if (xfer) begin
          if (in_data[7:4] != 4'd0) begin
            state_next = S_ERR;
          end else begin
            whi_next   = in_data[3:0];
`ifdef LOADER_CHECKSUM_EN
            csum_next  = csum_sum;
`endif
            state_next = S_W_LO;
          end
        end
      end

      S_W_LO: begin
        if (xfer) begin
          // Latch address and word now so they are stable during WRITE.
          mem_addr_next  = addr_reg;
          mem_wdata_next = {whi_reg, in_data};
`ifdef LOADER_CHECKSUM_EN
          csum_next      = csum_sum;
`endif
          state_next     = S_WRITE;
        end
      end

      S_WRITE: begin
        addr_next = addr_inc;
        if (addr_inc == count_reg) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = S_CHK;
`else
          state_next = S_DONE;
`endif
        end else begin
          state_next = S_W_HI;
        end
      end

      S_CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer) begin
          csum_next  = csum_sum;
          state_next = (csum_sum == 8'd0) ? S_DONE : S_ERR;
        end
`else
        // Unreachable without the checksum feature.
        state_next = S_IDLE;
`endif
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule
